// File: rtl/store_pkg.sv
// Shared types and constants for the store write path.
// Contents: store size encoding, beat geometry, formatter FSM states, and a
// helper that maps a store size to its unshifted byte-enable pattern.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } store_size_t;

  localparam int BEAT_BYTES    = 8;
  localparam int BEAT_OFF_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } fsm_state_t;

  // Byte enables for a store of the given size sitting at lane 0.
  function automatic logic [7:0] size_be(store_size_t sz);
    case (sz)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Truncates a register value to the store size and shifts it onto little-endian
// byte lanes of a two-beat (16-byte) window; purely combinational, no handshake.
// Ports: off (byte offset in beat), size, data -> d128 (lane data), be16 (enables).
module store_lane_shifter
  import store_pkg::*;
(
  input  logic [BEAT_OFF_BITS-1:0] off,
  input  store_size_t              size,
  input  logic [63:0]              data,
  output logic [127:0]             d128,
  output logic [15:0]              be16
);

  logic [7:0]  be8;
  logic [63:0] mask;

  always_comb begin
    be8  = size_be(size);
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{be8[i]}};
    end
    // Bytes pushed past lane 7 land in the upper half and form the second beat.
    d128 = {64'b0, data & mask} << {off, 3'b000};
    be16 = {8'b0, be8} << off;
  end

endmodule

// File: rtl/store_lane_formatter.sv
// Formats MEM-stage stores into 8-byte-aligned memory beats with byte enables,
// splitting boundary-crossing stores into two beats (beat0 then beat1).
// Latency 1 cycle from accept to beat on outputs; registered outputs held while
// mem_ready is low; req_ready drops while a second beat is still owed.
// Ports: clk/reset; req_valid/req_ready/req_addr/req_data/req_size in;
//        mem_valid/mem_ready/mem_addr/mem_wdata/mem_be out.
module store_lane_formatter
  import store_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [7:0]            mem_be
);

  fsm_state_t state, state_next;

  // Second beat of a crossing store, parked until beat0 is taken.
  logic                  b1_pend;
  logic [ADDR_WIDTH-1:0] b1_addr;
  logic [63:0]           b1_wdata;
  logic [7:0]            b1_be;

  logic [127:0]          d128;
  logic [15:0]           be16;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  second_pending;
  logic                  accept;
  logic                  handshake;
  logic                  load_req;
  logic                  load_b1;

  store_lane_shifter u_shifter (
    .off  (req_addr[BEAT_OFF_BITS-1:0]),
    .size (store_size_t'(req_size)),
    .data (req_data),
    .d128 (d128),
    .be16 (be16)
  );

  assign base_addr      = {req_addr[ADDR_WIDTH-1:BEAT_OFF_BITS], {BEAT_OFF_BITS{1'b0}}};
  assign mem_valid      = (state != ST_IDLE);
  assign second_pending = (state == ST_BEAT0) && b1_pend;
  // A new store may enter whenever the output slot frees up this cycle,
  // which keeps aligned back-to-back stores at one per clock.
  assign req_ready      = (state == ST_IDLE) || (mem_ready && !second_pending);
  assign accept         = req_valid && req_ready;
  assign handshake      = mem_valid && mem_ready;

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    load_b1    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_BEAT0;
          load_req   = 1'b1;
        end
      end
      ST_BEAT0: begin
        if (handshake) begin
          if (b1_pend) begin
            state_next = ST_BEAT1;
            load_b1    = 1'b1;
          end else if (accept) begin
            state_next = ST_BEAT0;
            load_req   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_BEAT1: begin
        if (handshake) begin
          if (accept) begin
            state_next = ST_BEAT0;
            load_req   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      b1_pend   <= 1'b0;
      b1_addr   <= '0;
      b1_wdata  <= '0;
      b1_be     <= '0;
    end else if (load_req) begin
      mem_addr  <= base_addr;
      mem_wdata <= d128[63:0];
      mem_be    <= be16[7:0];
      b1_pend   <= |be16[15:8];
      // Wraps to zero at the top of the address space.
      b1_addr   <= base_addr + ADDR_WIDTH'(BEAT_BYTES);
      b1_wdata  <= d128[127:64];
      b1_be     <= be16[15:8];
    end else if (load_b1) begin
      mem_addr  <= b1_addr;
      mem_wdata <= b1_wdata;
      mem_be    <= b1_be;
      b1_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_lane_formatter.sv
// Self-checking bench for store_lane_formatter: directed vector table, hand
// sequences for backpressure and reset mid-split, and a randomized phase
// scored against a byte-level reference model.
module tb_store_lane_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;

  always #5 clk = ~clk;

  store_lane_formatter #(.ADDR_WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [63:0] a0;
    logic [7:0]  be0;
    logic [63:0] w0;
    logic        two;
    logic [63:0] a1;
    logic [7:0]  be1;
    logic [63:0] w1;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
    mem_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_accept_ready", idx), req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_b0_valid", idx), mem_valid, 1);
    chk($sformatf("v%0d_b0_addr", idx), mem_addr, v.a0);
    chk($sformatf("v%0d_b0_be", idx), mem_be, v.be0);
    chk($sformatf("v%0d_b0_wdata", idx), mem_wdata, v.w0);
    if (v.two) begin
      chk($sformatf("v%0d_ready_between", idx), req_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_b1_valid", idx), mem_valid, 1);
      chk($sformatf("v%0d_b1_addr", idx), mem_addr, v.a1);
      chk($sformatf("v%0d_b1_be", idx), mem_be, v.be1);
      chk($sformatf("v%0d_b1_wdata", idx), mem_wdata, v.w1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", idx), mem_valid, 0);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } beat_t;

  beat_t expq[$];

  // Place each stored byte at its own byte address, then group by beat.
  function automatic void model_push(input logic [63:0] addr, input logic [63:0] data,
                                     input logic [1:0] size);
    int          n;
    int          k;
    int          lane;
    logic [63:0] a;
    logic [63:0] base;
    beat_t       b[2];
    n    = 1 << size;
    base = addr & ~64'h7;
    b[0] = '{base, 64'h0, 8'h0};
    b[1] = '{base + 64'd8, 64'h0, 8'h0};
    for (int i = 0; i < n; i++) begin
      a    = addr + 64'(i);
      k    = ((a & ~64'h7) == base) ? 0 : 1;
      lane = int'(a[2:0]);
      b[k].wdata[lane*8 +: 8] = data[i*8 +: 8];
      b[k].be[lane]           = 1'b1;
    end
    expq.push_back(b[0]);
    if (b[1].be != 8'h0) expq.push_back(b[1]);
  endfunction

  logic  rand_on = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rand_on) begin
        if (prev_stall) begin
          chk("hold_valid", mem_valid, 1);
          chk("hold_addr_wdata", {mem_addr, mem_wdata}, {prev_beat.addr, prev_beat.wdata});
          chk("hold_be", mem_be, prev_beat.be);
        end
        chk("rand_valid", mem_valid, expq.size() != 0);
        if (expq.size() == 0)      chk("rand_ready_idle", req_ready, 1);
        else if (expq.size() == 1) chk("rand_ready_follow", req_ready, mem_ready);
        else                       chk("rand_ready_split", req_ready, 0);
        if (mem_valid && mem_ready) begin
          if (expq.size() == 0) begin
            chk("rand_unexpected_beat", mem_valid, 0);
          end else begin
            e = expq.pop_front();
            chk("rand_addr", mem_addr, e.addr);
            chk("rand_be", mem_be, e.be);
            chk("rand_wdata", mem_wdata, e.wdata);
          end
        end
        if (req_valid && req_ready) model_push(req_addr, req_data, req_size);
        prev_stall      = mem_valid && !mem_ready;
        prev_beat.addr  = mem_addr;
        prev_beat.wdata = mem_wdata;
        prev_beat.be    = mem_be;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{64'h1003, 64'hDEADBEEF_CAFEF00D, 2'd0, 64'h1000, 8'h08,
                64'h00000000_0D000000, 1'b0, 64'h0, 8'h00, 64'h0};
    vecs[1] = '{64'h1005, 64'h11223344_55667788, 2'd3, 64'h1000, 8'hE0,
                64'h66778800_00000000, 1'b1, 64'h1008, 8'h1F, 64'h00000011_22334455};
    vecs[2] = '{64'h2007, 64'h0000ABCD, 2'd1, 64'h2000, 8'h80,
                64'hCD000000_00000000, 1'b1, 64'h2008, 8'h01, 64'hAB};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0A0B0C0D, 2'd2, 64'hFFFF_FFFF_FFFF_FFF8, 8'hC0,
                64'h0C0D0000_00000000, 1'b1, 64'h0, 8'h03, 64'h0A0B};
    vecs[4] = '{64'h40, 64'h01234567_89ABCDEF, 2'd3, 64'h40, 8'hFF,
                64'h01234567_89ABCDEF, 1'b0, 64'h0, 8'h00, 64'h0};
    vecs[5] = '{64'h32, 64'hFFFFFFFF_FFFF1234, 2'd1, 64'h30, 8'h0C,
                64'h00000000_12340000, 1'b0, 64'h0, 8'h00, 64'h0};
    vecs[6] = '{64'h07, 64'h01234567_89ABCDEF, 2'd2, 64'h00, 8'h80,
                64'hEF000000_00000000, 1'b1, 64'h08, 8'h07, 64'h00000000_0089ABCD};
    vecs[7] = '{64'h0F, 64'h11223344_55667788, 2'd0, 64'h08, 8'h80,
                64'h88000000_00000000, 1'b0, 64'h0, 8'h00, 64'h0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", mem_valid, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: word at 0x10 stalled 3 cycles, next store accepted on handshake.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 64'h10; req_data = 64'hFFFF0000_11223344; req_size = 2'd2;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_addr = 64'h20; req_data = 64'h5A; req_size = 2'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), mem_valid, 1);
      chk($sformatf("bp%0d_addr", c), mem_addr, 64'h10);
      chk($sformatf("bp%0d_be", c), mem_be, 8'h0F);
      chk($sformatf("bp%0d_wdata", c), mem_wdata, 64'h11223344);
      chk($sformatf("bp%0d_ready", c), req_ready, 0);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready", req_ready, 1);
    chk("bp_hs_addr", mem_addr, 64'h10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", mem_valid, 1);
    chk("bp_next_addr", mem_addr, 64'h20);
    chk("bp_next_be", mem_be, 8'h01);
    chk("bp_next_wdata", mem_wdata, 64'h5A);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle", mem_valid, 0);

    // Reset while beat0 of a crossing dword is held.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 64'h1005; req_data = 64'h11223344_55667788; req_size = 2'd3;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rs_held_be", mem_be, 8'hE0);
    #2;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rs_async_valid", mem_valid, 0);
    chk("rs_async_addr", mem_addr, 0);
    chk("rs_async_wdata", mem_wdata, 0);
    chk("rs_async_be", mem_be, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_ready_after", req_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rs_no_beat1_%0d", c), mem_valid, 0);
    end

    // Randomized phase scored by the reference model.
    @(posedge clk); #1;
    rand_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      req_size  = 2'($urandom_range(0, 3));
      req_data  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0)
        req_addr = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
      else
        req_addr = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (expq.size() != 0) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("rand_drain_empty", expq.size(), 0);
    @(posedge clk); #1;
    rand_on = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
